ex_issue_stage: RTL and testbench
=================================

EX_ISSUE_STAGE -- requirements
Module: ex_issue_stage

Interface
REQ-001 Parameter: none; all widths fixed (32-bit datapath, 5-bit register index, 6-bit func).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_b  input  1  reset; synchronous, active-high (asserted = 1 resets on next rising clk).
REQ-004 id_valid  input  1  decode presents an instruction.
REQ-005 id_ready  output  1  stage accepts the decode instruction this cycle.
REQ-006 id_func / id_inst  input  6 / 32  ALU func code, raw instruction word (shift amount in inst[10:6]).
REQ-007 id_rs, id_rt, id_rd  input  5 each  source/destination register indices.
REQ-008 id_rs_val, id_rt_val, id_imm  input  32 each  register-file reads, pre-extended immediate.
REQ-009 id_use_imm, id_reg_write, id_is_load  input  1 each  operand-2 select, writes rd, is a load.
REQ-010 flush  input  1  kill held and incoming instruction (taken branch).
REQ-011 mem_fwd_en, mem_fwd_reg, mem_fwd_data  input  1/5/32  forwarding source from MEM stage.
REQ-012 wb_fwd_en, wb_fwd_reg, wb_fwd_data  input  1/5/32  forwarding source from WB stage.
REQ-013 ex_valid  output  1  held instruction valid for the ALU.
REQ-014 ex_ready  input  1  downstream consumes held instruction this cycle.
REQ-015 input1w, input2w, a  output  32 each  ALU operand 1, operand 2, store data (forwarded rt).
REQ-016 funcw, inst  output  6 / 32  registered func and instruction word.
REQ-017 ex_rd, ex_reg_write, ex_is_load  output  5/1/1  registered destination info.
REQ-018 stall_cnt  output  16  saturating count of cycles with id_valid=1 and id_ready=0.

Function
REQ-019 Transfer in occurs when id_valid && id_ready; transfer out when ex_valid && ex_ready.
REQ-020 id_ready = !hazard && (!ex_valid || ex_ready), combinational.
REQ-021 hazard = ex_valid && ex_is_load && ex_reg_write && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt).
REQ-022 On hazard with ex_ready=1: held entry leaves, ex_valid becomes 0 (one bubble); decode instruction accepted next cycle.
REQ-023 Forwarded rs value: mem_fwd_data if mem_fwd_en && mem_fwd_reg==id_rs && id_rs!=0; else wb_fwd_data on same WB match; else id_rs_val. rt identical.
REQ-024 MEM forwarding has priority over WB when both match; register 0 never forwarded (always id value).
REQ-025 On accept: input1w <= fwd rs; a <= fwd rt; input2w <= id_use_imm ? id_imm : fwd rt; funcw, inst, ex_rd, ex_reg_write, ex_is_load loaded from id_*.
REQ-026 While held (ex_valid=1, ex_ready=0): each cycle a WB match on held rs/rt (held index !=0) refreshes input1w / a / input2w (input2w only if !use_imm); held indices stored internally.
REQ-027 Accept and drain in same cycle: new entry replaces old, ex_valid stays 1; zero bubble throughput of 1 instr/cycle.
REQ-028 flush=1: ex_valid <= 0 next cycle, id_ready forced 0, no accept; flush priority over accept and hold.
REQ-029 Invalid entry: ex_reg_write and ex_is_load outputs driven 0 regardless of stored bits.
REQ-030 stall_cnt increments by 1 per stall cycle, saturates at 16'hFFFF, no wrap; flush cycles not counted.
REQ-031 Arithmetic: no operand modification beyond select/forward; all 32 bits passed unchanged.

Reset
REQ-032 rst_b=1 at rising clk: ex_valid=0, input1w=input2w=a=0, funcw=0, inst=0, ex_rd=0, ex_reg_write=0, ex_is_load=0, stall_cnt=0.
REQ-033 Reset overrides flush, accept and hold; mid-operation reset discards held instruction with no output.
REQ-034 id_ready is 0 during reset cycle; first accept earliest the cycle after rst_b deasserts.

Verification
REQ-035 Back-to-back: add (rs=1,rt=2, vals 5,7) then sub, ex_ready=1 -> ex_valid continuous, input1w=5, input2w=7, funcw=6'b100000 then 6'b100010.
REQ-036 Forward priority: id_rs=3, mem_fwd(3,0xAAAA), wb_fwd(3,0xBBBB) -> input1w=0xAAAA; id_rs=0 with mem_fwd_reg=0 -> input1w=id_rs_val.
REQ-037 Load-use: held lw rd=4, incoming rs=4 -> id_ready=0 one cycle, ex_valid=0 bubble, stall_cnt=1, then accepted.
REQ-038 Backpressure: ex_ready=0 for 3 cycles, WB writes rt=5 value 0x1234 -> a=0x1234 on release, outputs otherwise stable.
REQ-039 Flush with id_valid=1, ex_valid=1 -> next cycle ex_valid=0, nothing accepted, stall_cnt unchanged.
REQ-040 Reset mid-hold and stall_cnt preloaded near 0xFFFF -> all outputs 0; separately 70000 stall cycles -> stall_cnt=0xFFFF.

Source files
------------

// File: rtl/ex_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_issue_stage
// Summary  : Decode-to-execute issue register with operand forwarding from the
//            MEM/WB stages. It detects load-use hazards, applies backpressure
//            and flush, refreshes held operands from WB, and keeps a
//            saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_issue_stage (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [5:0]  id_func,
  input  logic [31:0] id_inst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic        id_reg_write,
  input  logic        id_is_load,
  input  logic        flush,
  input  logic        mem_fwd_en,
  input  logic [4:0]  mem_fwd_reg,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_fwd_en,
  input  logic [4:0]  wb_fwd_reg,
  input  logic [31:0] wb_fwd_data,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] input1w,
  output logic [31:0] input2w,
  output logic [31:0] a,
  output logic [5:0]  funcw,
  output logic [31:0] inst,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_is_load,
  output logic [15:0] stall_cnt
);

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  // Held-entry bookkeeping that is not exposed directly on the ports
  logic        valid_q;
  logic        reg_write_q;
  logic        is_load_q;
  logic        use_imm_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;

  logic        hazard;
  logic        accept;
  logic        stall;
  logic        hold;
  logic        wb_hit_rs;
  logic        wb_hit_rt;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // MEM beats WB; register 0 always reads the register-file value
  function automatic logic [31:0] fwd_pick(input logic [4:0] idx, input logic [31:0] rf_val);
    if (idx != 5'd0 && mem_fwd_en && mem_fwd_reg == idx)
      fwd_pick = mem_fwd_data;
    else if (idx != 5'd0 && wb_fwd_en && wb_fwd_reg == idx)
      fwd_pick = wb_fwd_data;
    else
      fwd_pick = rf_val;
  endfunction

  // Handshake, hazard detection and operand forwarding
  always_comb begin
    hazard    = valid_q && is_load_q && reg_write_q && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs) || (ex_rd == id_rt));
    id_ready  = !rst_b && !flush && !hazard && (!valid_q || ex_ready);
    accept    = id_valid && id_ready;
    stall     = id_valid && !id_ready && !flush;
    hold      = valid_q && !ex_ready;
    wb_hit_rs = wb_fwd_en && (rs_q != 5'd0) && (wb_fwd_reg == rs_q);
    wb_hit_rt = wb_fwd_en && (rt_q != 5'd0) && (wb_fwd_reg == rt_q);
    fwd_rs    = fwd_pick(id_rs, id_rs_val);
    fwd_rt    = fwd_pick(id_rt, id_rt_val);
  end

  // Stored control bits are hidden while the entry is invalid
  assign ex_valid     = valid_q;
  assign ex_reg_write = valid_q & reg_write_q;
  assign ex_is_load   = valid_q & is_load_q;

  // Issue register: reset > flush > accept > drain > hold-refresh
  always_ff @(posedge clk) begin
    if (rst_b) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      use_imm_q   <= 1'b0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      input1w     <= 32'd0;
      input2w     <= 32'd0;
      a           <= 32'd0;
      funcw       <= 6'd0;
      inst        <= 32'd0;
      ex_rd       <= 5'd0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      reg_write_q <= id_reg_write;
      is_load_q   <= id_is_load;
      use_imm_q   <= id_use_imm;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      input1w     <= fwd_rs;
      a           <= fwd_rt;
      input2w     <= id_use_imm ? id_imm : fwd_rt;
      funcw       <= id_func;
      inst        <= id_inst;
      ex_rd       <= id_rd;
    end else if (valid_q && ex_ready) begin
      valid_q <= 1'b0;
    end else if (hold) begin
      if (wb_hit_rs)
        input1w <= wb_fwd_data;
      if (wb_hit_rt) begin
        a <= wb_fwd_data;
        if (!use_imm_q)
          input2w <= wb_fwd_data;
      end
    end
  end

  // Saturating count of cycles where decode was blocked (flush excluded)
  always_ff @(posedge clk) begin
    if (rst_b)
      stall_cnt <= 16'd0;
    else if (stall && stall_cnt != STALL_MAX)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_issue_stage
// Summary  : Directed bench for ex_issue_stage with a transaction-level model
//            checked every cycle plus hand-computed literal checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        id_valid;
  logic        id_ready;
  logic [5:0]  id_func;
  logic [31:0] id_inst;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic        id_use_imm, id_reg_write, id_is_load;
  logic        flush;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_reg;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_en;
  logic [4:0]  wb_fwd_reg;
  logic [31:0] wb_fwd_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] input1w, input2w, a;
  logic [5:0]  funcw;
  logic [31:0] inst;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_is_load;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  bit model_on = 1'b0;

  ex_issue_stage dut (
    .clk(clk), .rst_b(rst_b), .id_valid(id_valid), .id_ready(id_ready),
    .id_func(id_func), .id_inst(id_inst), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .flush(flush), .mem_fwd_en(mem_fwd_en), .mem_fwd_reg(mem_fwd_reg), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_reg(wb_fwd_reg), .wb_fwd_data(wb_fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .input1w(input1w), .input2w(input2w), .a(a),
    .funcw(funcw), .inst(inst), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction-slot view) ----------------
  bit          m_valid;
  logic [31:0] m_in1, m_in2, m_a, m_inst;
  logic [5:0]  m_func;
  logic [4:0]  m_rd, m_rs, m_rt;
  bit          m_rw, m_ld, m_imm;
  int          m_stall;

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] v);
    logic [31:0] res;
    res = v;
    if (r != 0) begin
      if (wb_fwd_en && wb_fwd_reg == r) res = wb_fwd_data;
      if (mem_fwd_en && mem_fwd_reg == r) res = mem_fwd_data;
    end
    return res;
  endfunction

  function automatic bit m_ready();
    bit load_use;
    load_use = m_valid && m_ld && m_rw && m_rd != 0 && (m_rd == id_rs || m_rd == id_rt);
    return !rst_b && !flush && !load_use && (!m_valid || ex_ready);
  endfunction

  // Model advance on each rising edge
  always @(posedge clk) begin
    if (rst_b) begin
      m_valid <= 0; m_in1 <= 0; m_in2 <= 0; m_a <= 0; m_inst <= 0; m_func <= 0;
      m_rd <= 0; m_rs <= 0; m_rt <= 0; m_rw <= 0; m_ld <= 0; m_imm <= 0; m_stall <= 0;
    end else if (!flush) begin
      if (id_valid && m_ready()) begin
        m_valid <= 1; m_rs <= id_rs; m_rt <= id_rt; m_rd <= id_rd;
        m_in1 <= m_fwd(id_rs, id_rs_val);
        m_a   <= m_fwd(id_rt, id_rt_val);
        m_in2 <= id_use_imm ? id_imm : m_fwd(id_rt, id_rt_val);
        m_func <= id_func; m_inst <= id_inst;
        m_rw <= id_reg_write; m_ld <= id_is_load; m_imm <= id_use_imm;
      end else if (m_valid && ex_ready) begin
        m_valid <= 0;
      end else if (m_valid) begin
        if (wb_fwd_en && m_rs != 0 && wb_fwd_reg == m_rs) m_in1 <= wb_fwd_data;
        if (wb_fwd_en && m_rt != 0 && wb_fwd_reg == m_rt) begin
          m_a <= wb_fwd_data;
          if (!m_imm) m_in2 <= wb_fwd_data;
        end
      end
      if (id_valid && !m_ready()) m_stall <= (m_stall >= 65535) ? 65535 : m_stall + 1;
    end else begin
      m_valid <= 0;
    end
  end

  // Per-cycle comparison mid-cycle
  always @(negedge clk) begin
    if (model_on) begin
      chk("id_ready", {31'd0, id_ready}, {31'd0, m_ready()});
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      chk("input1w", input1w, m_in1);
      chk("input2w", input2w, m_in2);
      chk("a", a, m_a);
      chk("funcw", {26'd0, funcw}, {26'd0, m_func});
      chk("inst", inst, m_inst);
      chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
      chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_valid && m_rw});
      chk("ex_is_load", {31'd0, ex_is_load}, {31'd0, m_valid && m_ld});
      chk("stall_cnt", {16'd0, stall_cnt}, m_stall[31:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_func = 0; id_inst = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_val = 0; id_rt_val = 0; id_imm = 0; id_use_imm = 0; id_reg_write = 0;
    id_is_load = 0; flush = 0; mem_fwd_en = 0; mem_fwd_reg = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_reg = 0; wb_fwd_data = 0; ex_ready = 1;
  endtask

  task automatic drive_instr(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                             input bit rw, input bit ld);
    id_valid = 1; id_func = f; id_inst = {f, rs, rt, rd, 10'h0, 1'b1};
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_val = rsv; id_rt_val = rtv;
    id_reg_write = rw; id_is_load = ld; id_use_imm = 0;
  endtask

  initial begin
    idle_inputs();
    rst_b = 1;
    step(); step();
    model_on = 1;
    chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset id_ready", {31'd0, id_ready}, 32'd0);
    chk("reset input1w", input1w, 32'd0);
    chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst_b = 0;
    step();

    // Back-to-back add then sub
    drive_instr(6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1, 0);
    step();
    chk("b2b add funcw", {26'd0, funcw}, 32'h20);
    chk("b2b add input1w", input1w, 32'd5);
    chk("b2b add input2w", input2w, 32'd7);
    drive_instr(6'b100010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1, 0);
    step();
    chk("b2b sub ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("b2b sub funcw", {26'd0, funcw}, 32'h22);
    chk("b2b sub input2w", input2w, 32'd7);
    idle_inputs();
    step();

    // Forwarding priority
    drive_instr(6'h20, 5'd3, 5'd0, 5'd6, 32'h1111, 32'h9, 1, 0);
    mem_fwd_en = 1; mem_fwd_reg = 5'd3; mem_fwd_data = 32'hAAAA;
    wb_fwd_en = 1; wb_fwd_reg = 5'd3; wb_fwd_data = 32'hBBBB;
    step();
    chk("fwd mem priority", input1w, 32'hAAAA);
    chk("fwd rt0 a", a, 32'h9);
    id_rs = 5'd0; id_rs_val = 32'h2222; mem_fwd_reg = 5'd0; wb_fwd_reg = 5'd0;
    step();
    chk("fwd reg0 none", input1w, 32'h2222);
    mem_fwd_en = 0; id_rs = 5'd3; wb_fwd_reg = 5'd3;
    id_rt = 5'd3; id_rt_val = 32'h77; id_use_imm = 1; id_imm = 32'hFFFF_FFF0;
    step();
    chk("fwd wb only", input1w, 32'hBBBB);
    chk("imm input2w", input2w, 32'hFFFF_FFF0);
    chk("imm store a", a, 32'hBBBB);
    idle_inputs();
    step();

    // Load-use hazard: one bubble then accept
    drive_instr(6'h23, 5'd1, 5'd0, 5'd4, 32'h10, 32'h0, 1, 1);
    step();
    chk("lw held is_load", {31'd0, ex_is_load}, 32'd1);
    drive_instr(6'h20, 5'd4, 5'd2, 5'd5, 32'h44, 32'h2, 1, 0);
    #1;
    chk("lu id_ready low", {31'd0, id_ready}, 32'd0);
    step();
    chk("lu bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu stall_cnt", {16'd0, stall_cnt}, 32'd1);
    step();
    chk("lu accepted", {31'd0, ex_valid}, 32'd1);
    chk("lu input1w", input1w, 32'h44);
    idle_inputs();
    step();

    // Backpressure with WB refresh of held rt
    drive_instr(6'h21, 5'd6, 5'd5, 5'd7, 32'h66, 32'h0, 1, 0);
    ex_ready = 0;
    step();
    id_valid = 0;
    wb_fwd_en = 1; wb_fwd_reg = 5'd5; wb_fwd_data = 32'h1234;
    repeat (3) step();
    chk("bp a refreshed", a, 32'h1234);
    chk("bp input1w stable", input1w, 32'h66);
    wb_fwd_en = 0; ex_ready = 1;
    step();
    chk("bp released", {31'd0, ex_valid}, 32'd0);
    chk("bp input2w", input2w, 32'h1234);
    idle_inputs();
    step();

    // Flush with held entry and incoming instruction
    drive_instr(6'h24, 5'd8, 5'd9, 5'd10, 32'h8, 32'h9, 1, 0);
    ex_ready = 0;
    step();
    drive_instr(6'h25, 5'd11, 5'd12, 5'd13, 32'hB, 32'hC, 1, 0);
    flush = 1;
    step();
    chk("flush ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush funcw kept", {26'd0, funcw}, 32'h24);
    chk("flush stall_cnt", {16'd0, stall_cnt}, 32'd1);
    idle_inputs();
    step();

    // Long stall to saturate, then reset mid-hold
    drive_instr(6'h26, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1, 0);
    ex_ready = 0;
    step();
    repeat (70000) step();
    chk("sat stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    rst_b = 1;
    step();
    chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst input1w", input1w, 32'd0);
    chk("rst funcw", {26'd0, funcw}, 32'd0);
    chk("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
    rst_b = 0;
    idle_inputs();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
